seg14_scan_decoder: RTL and testbench
=====================================

Name: seg14_scan_decoder

Overview:
- Receive-side counterpart of the 12-digit 14-segment scan driver.
- Samples the multiplexed one-hot digit-select bus and segment bus, and validates the scan order.
- Decodes each 14-segment pattern back to an ASCII character and presents a complete 12-character frame through a valid/ready handshake.
- Used as an on-chip loopback monitor and as a bus-functional checker for the display path.

Parameters:
- NUM_DIGITS, 12, number of scanned digit positions (one-hot select width).
- SEG_W, 14, segment bus width.
- CHAR_W, 8, decoded character width (ASCII).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sel_i  in  NUM_DIGITS  one-hot digit select from the scan driver; bit k = digit k.
- segm_i  in  SEG_W  segment pattern for the selected digit.
- frame_chars_o  out  NUM_DIGITS*CHAR_W  decoded frame; digit 0 in bits [7:0].
- unknown_o  out  NUM_DIGITS  per-digit flag: pattern not in the font table.
- frame_valid_o  out  1  frame available; held until accepted.
- frame_ready_i  in  1  consumer accepts the frame when valid && ready.
- seq_err_o  out  1  one-cycle pulse on a scan-order violation.
- overflow_o  out  1  sticky: a complete frame was dropped.
- ovf_clr_i  in  1  synchronous clear of overflow_o.

Behaviour:
- Reset: all outputs 0; frame and shadow buffers 0; FSM in HUNT. Reset is asynchronous, so it takes effect mid-collection and discards the partial frame.
- Stage 1 registers sel_i/segm_i every cycle. Stage 2 performs the FSM update and the decode into the shadow buffer.
- FSM states: HUNT, COLLECT.
- HUNT:
  - Ignore everything until the registered sel == bit 0.
  - Then store decode(seg) into shadow[0], set exp = 1, and go to COLLECT.
- COLLECT, registered sel == bit exp:
  - Store to shadow[exp], exp++.
  - If exp was NUM_DIGITS-1: commit the frame and return to HUNT.
- COLLECT, any other sel value (zero, multi-hot, out of order): pulse seq_err_o, discard the shadow buffer, go to HUNT.
  - If that same sel == bit 0, restart directly: store shadow[0], exp = 1, stay in COLLECT.
- Commit rules:
  - If frame_valid_o == 0, or a valid && ready handshake occurs in the same cycle: copy shadow and unknown flags to the outputs and set frame_valid_o = 1.
  - Otherwise drop the frame, set overflow_o, and leave the outputs unchanged.
- Latency: last digit present on the inputs before edge N → frame_valid_o high after edge N+1.
- Handshake:
  - frame_valid_o deasserts on the edge where valid && ready, unless a new commit occurs in that same cycle.
  - frame_chars_o is stable while frame_valid_o is high.
- Decode is exact match against the font table, no partial matching. No match → char 0x3F ('?') and unknown bit = 1.
- overflow_o: set has priority over ovf_clr_i when both occur in the same cycle.
- exp counter is 4 bits and never exceeds NUM_DIGITS-1; there is no wrap inside COLLECT.

Optional Feature:
- Macro SEG14_SCAN_HOLD_EN.
- Defined:
  - A repeated sel equal to the digit just stored (bit exp-1) is legal; the shadow entry is overwritten (last sample wins).
  - This supports prescaled scan drivers that hold each digit for several clocks.
  - Commit happens on the first sample of digit NUM_DIGITS-1. Later repeats of that digit are ignored in HUNT.
- Undefined: a repeated sel is a sequence error.

Decomposition:
- Package seg14_pkg:
  - Font constants: A=14'b11101111000000, C=14'b10011100000000, D=14'b11110000010010, E=14'b10011110000000, I=14'b10010000010010, L=14'b00011100000000, O=14'b11111100000000, P=14'b11001111000000, S=14'b10110111000000, T=14'b10000000010010, U=14'b01111100000000, SPACE=14'b0.
  - ASCII codes for each constant, plus CHAR_UNKNOWN=8'h3F.
  - FSM state typedef.
- Sub-module seg14_char_lookup: combinational, pattern → {unknown, char}. Instantiated once in stage 2.

Test Plan:
- Clean scan of "CAPITULO EDS" (digit k selected in cycle k, 12 cycles, ready=1) → 2 cycles after digit 11: frame_valid_o=1, frame_chars_o = ASCII "CAPITULO EDS", unknown_o=0, seq_err_o never asserted.
- ready=0, two consecutive full frames → first frame held, second dropped, overflow_o=1. Then ready=1 → valid drops next edge. Then ovf_clr_i → overflow_o=0.
- sel=12'h003 during digit 2 → seq_err_o high for exactly 1 cycle, no commit. The following clean frame decodes correctly.
- Stimulus starts at digit 5 → no output until digit 0 is seen; frame_valid_o rises 13 cycles after digit 0 is applied.
- segm=14'h3FFF on digit 4 → char[4]=0x3F, unknown_o = 12'h010, other chars correct.
- rst_n pulled low at digit 7 → all outputs 0 asynchronously; the next clean frame decodes correctly.
- With SEG14_SCAN_HOLD_EN, each digit held 3 cycles → a correct frame and no seq_err.
- Without SEG14_SCAN_HOLD_EN, each digit held 3 cycles → seq_err_o pulses.

Source files
------------

// File: rtl/seg14_pkg.sv
// seg14_pkg: shared constants for the 14-segment scan decoder.
// Holds the font table, matching ASCII codes and the collector FSM state type.
package seg14_pkg;

  localparam int unsigned SEG14_NUM_DIGITS = 12;
  localparam int unsigned SEG14_SEG_W      = 14;
  localparam int unsigned SEG14_CHAR_W     = 8;
  localparam int unsigned EXP_W            = 4;

  // Segment patterns understood by the decoder
  localparam logic [SEG14_SEG_W-1:0] SEG_A     = 14'b11101111000000;
  localparam logic [SEG14_SEG_W-1:0] SEG_C     = 14'b10011100000000;
  localparam logic [SEG14_SEG_W-1:0] SEG_D     = 14'b11110000010010;
  localparam logic [SEG14_SEG_W-1:0] SEG_E     = 14'b10011110000000;
  localparam logic [SEG14_SEG_W-1:0] SEG_I     = 14'b10010000010010;
  localparam logic [SEG14_SEG_W-1:0] SEG_L     = 14'b00011100000000;
  localparam logic [SEG14_SEG_W-1:0] SEG_O     = 14'b11111100000000;
  localparam logic [SEG14_SEG_W-1:0] SEG_P     = 14'b11001111000000;
  localparam logic [SEG14_SEG_W-1:0] SEG_S     = 14'b10110111000000;
  localparam logic [SEG14_SEG_W-1:0] SEG_T     = 14'b10000000010010;
  localparam logic [SEG14_SEG_W-1:0] SEG_U     = 14'b01111100000000;
  localparam logic [SEG14_SEG_W-1:0] SEG_SPACE = 14'b00000000000000;

  // ASCII codes returned for each pattern
  localparam logic [SEG14_CHAR_W-1:0] CHAR_A       = 8'h41;
  localparam logic [SEG14_CHAR_W-1:0] CHAR_C       = 8'h43;
  localparam logic [SEG14_CHAR_W-1:0] CHAR_D       = 8'h44;
  localparam logic [SEG14_CHAR_W-1:0] CHAR_E       = 8'h45;
  localparam logic [SEG14_CHAR_W-1:0] CHAR_I       = 8'h49;
  localparam logic [SEG14_CHAR_W-1:0] CHAR_L       = 8'h4C;
  localparam logic [SEG14_CHAR_W-1:0] CHAR_O       = 8'h4F;
  localparam logic [SEG14_CHAR_W-1:0] CHAR_P       = 8'h50;
  localparam logic [SEG14_CHAR_W-1:0] CHAR_S       = 8'h53;
  localparam logic [SEG14_CHAR_W-1:0] CHAR_T       = 8'h54;
  localparam logic [SEG14_CHAR_W-1:0] CHAR_U       = 8'h55;
  localparam logic [SEG14_CHAR_W-1:0] CHAR_SPACE   = 8'h20;
  localparam logic [SEG14_CHAR_W-1:0] CHAR_UNKNOWN = 8'h3F;

  typedef enum logic {
    ST_HUNT    = 1'b0,
    ST_COLLECT = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg14_char_lookup.sv
// seg14_char_lookup: exact-match 14-segment pattern to ASCII decode.
// Unmatched patterns return '?' with the unknown flag set.
module seg14_char_lookup
  import seg14_pkg::*;
(
  input  logic [SEG14_SEG_W-1:0]  seg,
  output logic [SEG14_CHAR_W-1:0] ch_c,
  output logic                    unknown_c
);

  // Font table match; no partial matching
  always_comb begin
    ch_c      = CHAR_UNKNOWN;
    unknown_c = 1'b1;
    case (seg)
      SEG_A:     begin ch_c = CHAR_A;     unknown_c = 1'b0; end
      SEG_C:     begin ch_c = CHAR_C;     unknown_c = 1'b0; end
      SEG_D:     begin ch_c = CHAR_D;     unknown_c = 1'b0; end
      SEG_E:     begin ch_c = CHAR_E;     unknown_c = 1'b0; end
      SEG_I:     begin ch_c = CHAR_I;     unknown_c = 1'b0; end
      SEG_L:     begin ch_c = CHAR_L;     unknown_c = 1'b0; end
      SEG_O:     begin ch_c = CHAR_O;     unknown_c = 1'b0; end
      SEG_P:     begin ch_c = CHAR_P;     unknown_c = 1'b0; end
      SEG_S:     begin ch_c = CHAR_S;     unknown_c = 1'b0; end
      SEG_T:     begin ch_c = CHAR_T;     unknown_c = 1'b0; end
      SEG_U:     begin ch_c = CHAR_U;     unknown_c = 1'b0; end
      SEG_SPACE: begin ch_c = CHAR_SPACE; unknown_c = 1'b0; end
      default:   begin end
    endcase
  end

endmodule

// File: rtl/seg14_scan_decoder.sv
// seg14_scan_decoder: samples a one-hot scanned 14-segment display bus, checks
// the scan order, decodes each digit and hands out whole frames via valid/ready.
// Build option: define SEG14_SCAN_HOLD_EN to accept digits held for several
// clocks (a repeat of the digit just stored overwrites it).
module seg14_scan_decoder
  import seg14_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = SEG14_NUM_DIGITS,
  parameter int unsigned SEG_W      = SEG14_SEG_W,
  parameter int unsigned CHAR_W     = SEG14_CHAR_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_DIGITS-1:0]        sel_i,
  input  logic [SEG_W-1:0]             segm_i,
  output logic [NUM_DIGITS*CHAR_W-1:0] frame_chars_o,
  output logic [NUM_DIGITS-1:0]        unknown_o,
  output logic                         frame_valid_o,
  input  logic                         frame_ready_i,
  output logic                         seq_err_o,
  output logic                         overflow_o,
  input  logic                         ovf_clr_i
);

  localparam int unsigned LAST = NUM_DIGITS - 1;

  logic [NUM_DIGITS-1:0]              sel_q;
  logic [SEG_W-1:0]                   seg_q;
  scan_state_e                        state_q, state_d;
  logic [EXP_W-1:0]                   exp_q, exp_d;
  logic [NUM_DIGITS-1:0][CHAR_W-1:0]  shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]              unk_q, unk_d;
  logic [NUM_DIGITS-1:0]              exp_hot_c;
  logic [CHAR_W-1:0]                  dec_char_c;
  logic                               dec_unknown_c;
  logic                               commit_c;
  logic                               seq_err_c;
  logic                               accept_c;
`ifdef SEG14_SCAN_HOLD_EN
  logic [EXP_W-1:0]                   prev_idx_c;
  logic [NUM_DIGITS-1:0]              prev_hot_c;
`endif

  // Stage 1: register the raw scan bus every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= '0;
      seg_q <= '0;
    end else begin
      sel_q <= sel_i;
      seg_q <= segm_i;
    end
  end

  seg14_char_lookup u_lookup (
    .seg       (seg_q),
    .ch_c      (dec_char_c),
    .unknown_c (dec_unknown_c)
  );

  assign exp_hot_c = NUM_DIGITS'(1) << exp_q;
  assign accept_c  = frame_valid_o & frame_ready_i;
`ifdef SEG14_SCAN_HOLD_EN
  assign prev_idx_c = exp_q - EXP_W'(1);
  assign prev_hot_c = NUM_DIGITS'(1) << prev_idx_c;
`endif

  // Stage 2 state register: collector FSM, expected digit and shadow frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_HUNT;
      exp_q    <= '0;
      shadow_q <= '0;
      unk_q    <= '0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      shadow_q <= shadow_d;
      unk_q    <= unk_d;
    end
  end

  // Stage 2 next state: scan-order check and decode into the shadow frame
  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    shadow_d  = shadow_q;
    unk_d     = unk_q;
    commit_c  = 1'b0;
    seq_err_c = 1'b0;
    case (state_q)
      ST_HUNT: begin
        if (sel_q == NUM_DIGITS'(1)) begin
          shadow_d[0] = dec_char_c;
          unk_d[0]    = dec_unknown_c;
          exp_d       = EXP_W'(1);
          state_d     = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (sel_q == exp_hot_c) begin
          shadow_d[exp_q] = dec_char_c;
          unk_d[exp_q]    = dec_unknown_c;
          if (exp_q == EXP_W'(LAST)) begin
            commit_c = 1'b1;
            exp_d    = '0;
            state_d  = ST_HUNT;
          end else begin
            exp_d = exp_q + EXP_W'(1);
          end
        end
`ifdef SEG14_SCAN_HOLD_EN
        else if (sel_q == prev_hot_c) begin
          // Held digit: latest sample replaces the stored one
          shadow_d[prev_idx_c] = dec_char_c;
          unk_d[prev_idx_c]    = dec_unknown_c;
        end
`endif
        else begin
          seq_err_c = 1'b1;
          shadow_d  = '0;
          unk_d     = '0;
          if (sel_q == NUM_DIGITS'(1)) begin
            // A digit-0 select is itself a valid frame start
            shadow_d[0] = dec_char_c;
            unk_d[0]    = dec_unknown_c;
            exp_d       = EXP_W'(1);
          end else begin
            exp_d   = '0;
            state_d = ST_HUNT;
          end
        end
      end
      default: begin
        state_d = ST_HUNT;
        exp_d   = '0;
      end
    endcase
  end

  // Output frame, handshake, error pulse and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_chars_o <= '0;
      unknown_o     <= '0;
      frame_valid_o <= 1'b0;
      seq_err_o     <= 1'b0;
      overflow_o    <= 1'b0;
    end else begin
      seq_err_o <= seq_err_c;
      if (commit_c && (!frame_valid_o || accept_c)) begin
        frame_chars_o <= shadow_d;
        unknown_o     <= unk_d;
        frame_valid_o <= 1'b1;
      end else if (accept_c) begin
        frame_valid_o <= 1'b0;
      end
      if (commit_c && frame_valid_o && !accept_c) begin
        overflow_o <= 1'b1;
      end else if (ovf_clr_i) begin
        overflow_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg14_scan_decoder.sv
// tb_seg14_scan_decoder: randomized and directed stimulus for the scan decoder,
// with a string-level reference model feeding a frame scoreboard.
// Honours SEG14_SCAN_HOLD_EN the same way as the design build.
module tb_seg14_scan_decoder;

  localparam int ND = 12;
`ifdef SEG14_SCAN_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [11:0]   sel_i = '0;
  logic [13:0]   segm_i = '0;
  logic          frame_ready_i = 1'b0;
  logic          ovf_clr_i = 1'b0;
  logic [95:0]   frame_chars_o;
  logic [11:0]   unknown_o;
  logic          frame_valid_o;
  logic          seq_err_o;
  logic          overflow_o;

  always #5 clk = ~clk;

  seg14_scan_decoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sel_i         (sel_i),
    .segm_i        (segm_i),
    .frame_chars_o (frame_chars_o),
    .unknown_o     (unknown_o),
    .frame_valid_o (frame_valid_o),
    .frame_ready_i (frame_ready_i),
    .seq_err_o     (seq_err_o),
    .overflow_o    (overflow_o),
    .ovf_clr_i     (ovf_clr_i)
  );

  // Font as written in the display documentation
  logic [13:0] font_seg [12] = '{14'b11101111000000, 14'b10011100000000, 14'b11110000010010,
                                 14'b10011110000000, 14'b10010000010010, 14'b00011100000000,
                                 14'b11111100000000, 14'b11001111000000, 14'b10110111000000,
                                 14'b10000000010010, 14'b01111100000000, 14'b00000000000000};
  logic [7:0]  font_chr [12] = '{8'h41, 8'h43, 8'h44, 8'h45, 8'h49, 8'h4C,
                                 8'h4F, 8'h50, 8'h53, 8'h54, 8'h55, 8'h20};

  typedef struct {
    logic [95:0] chars;
    logic [11:0] unk;
  } frame_t;

  frame_t      sb_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          ready_mode = 0;   // 0 random consumer, 1 never ready, 2 always ready
  int          seen_err = 0;     // cycles with seq_err_o high
  int          age = 0;

  // Reference model state
  bit          m_collect = 1'b0;
  int          m_exp = 0;
  logic [95:0] m_frame = '0;
  logic [11:0] m_unk = '0;
  int          m_err = 0;
  logic        m_ovf = 1'b0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [13:0] pat_of(input logic [7:0] c);
    for (int i = 0; i < 12; i++) if (font_chr[i] == c) return font_seg[i];
    return 14'h3FFF;
  endfunction

  function automatic logic [95:0] pack_str(input string s);
    logic [95:0] r = '0;
    for (int k = 0; k < ND; k++) r[k*8 +: 8] = s[k];
    return r;
  endfunction

  function automatic int digit_of(input logic [11:0] sel);
    if ($countones(sel) != 1) return -1;
    for (int i = 0; i < ND; i++) if (sel[i]) return i;
    return -1;
  endfunction

  task automatic model_store(input int d, input logic [13:0] p);
    logic [7:0] c = 8'h3F;
    logic       u = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (font_seg[i] == p) begin
        c = font_chr[i];
        u = 1'b0;
      end
    end
    m_frame[d*8 +: 8] = c;
    m_unk[d] = u;
  endtask

  task automatic model_complete();
    frame_t f;
    f.chars = m_frame;
    f.unk   = m_unk;
    if (ready_mode == 1 && sb_q.size() > 0) m_ovf = 1'b1;
    else sb_q.push_back(f);
  endtask

  // Scan-order rules applied to the stream of samples in issue order
  task automatic model_sample(input logic [11:0] sel, input logic [13:0] p);
    int d = digit_of(sel);
    if (!m_collect) begin
      if (d == 0) begin
        m_frame = '0; m_unk = '0;
        model_store(0, p);
        m_collect = 1'b1; m_exp = 1;
      end
    end else if (d == m_exp) begin
      model_store(d, p);
      if (m_exp == ND - 1) begin
        model_complete();
        m_collect = 1'b0;
      end else begin
        m_exp++;
      end
    end else if (HOLD && d == m_exp - 1) begin
      model_store(d, p);
    end else begin
      m_err++;
      m_frame = '0; m_unk = '0;
      if (d == 0) begin
        model_store(0, p);
        m_exp = 1;
      end else begin
        m_collect = 1'b0;
      end
    end
  endtask

  task automatic drive(input logic [11:0] sel, input logic [13:0] p);
    @(posedge clk);
    #1;
    sel_i  = sel;
    segm_i = p;
    model_sample(sel, p);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, '0);
  endtask

  task automatic send_str(input string s, input int hold);
    for (int k = 0; k < ND; k++)
      for (int h = 0; h < hold; h++) drive(12'(1) << k, pat_of(s[k]));
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    check("drain_scoreboard", 96'(sb_q.size()), 96'(0));
  endtask

  // Consumer: drives ready shortly after each edge
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        1:       frame_ready_i = 1'b0;
        2:       frame_ready_i = 1'b1;
        default: frame_ready_i = (age >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on each handshake, checks hold stability
  initial begin
    frame_t      e;
    logic        held = 1'b0;
    logic [95:0] prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
        age  = 0;
      end else begin
        if (seq_err_o) seen_err++;
        if (frame_valid_o && held) check("stable_while_valid", frame_chars_o, prev);
        if (frame_valid_o && frame_ready_i) begin
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_frame: got %0h expected none", frame_chars_o);
          end else begin
            e = sb_q.pop_front();
            check("frame_chars", frame_chars_o, e.chars);
            check("frame_unknown", 96'(unknown_o), 96'(e.unk));
          end
          held = 1'b0;
          age  = 0;
        end else if (frame_valid_o) begin
          held = 1'b1;
          prev = frame_chars_o;
          age++;
        end else begin
          held = 1'b0;
          age  = 0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   err_base;
    int   merr_base;
    int   cnt;
    int   nj;
    int   bad_pos;
    logic [11:0] js;
    logic [13:0] pats [12];
    logic [7:0]  chs [12];

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 96'(frame_valid_o), 96'(0));
    check("rst_chars", frame_chars_o, 96'(0));
    check("rst_unknown", 96'(unknown_o), 96'(0));
    check("rst_ovf", 96'(overflow_o), 96'(0));
    check("rst_seq_err", 96'(seq_err_o), 96'(0));
    rst_n = 1'b1;
    idle(2);

    // Clean frame with latency check
    ready_mode = 2;
    err_base = seen_err; merr_base = m_err;
    send_str("CAPITULO EDS", 1);
    @(posedge clk); #1;
    check("lat_not_yet", 96'(frame_valid_o), 96'(0));
    @(posedge clk); #1;
    check("lat_valid", 96'(frame_valid_o), 96'(1));
    check("clean_chars", frame_chars_o, pack_str("CAPITULO EDS"));
    check("clean_unknown", 96'(unknown_o), 96'(0));
    idle(3);
    drain();
    check("clean_no_err", 96'(seen_err - err_base), 96'(0));

    // Overflow: two frames while the consumer stalls
    ready_mode = 1;
    idle(2);
    send_str("SALIDA TOPE ", 1);
    send_str("PLATO SUCIO ", 1);
    idle(3);
    check("ovf_set", 96'(overflow_o), 96'(m_ovf));
    check("ovf_held_valid", 96'(frame_valid_o), 96'(1));
    check("ovf_first_kept", frame_chars_o, pack_str("SALIDA TOPE "));
    ready_mode = 2;
    @(posedge clk); #1;
    check("accept_drops_valid", 96'(frame_valid_o), 96'(0));
    check("ovf_sticky", 96'(overflow_o), 96'(1));
    ovf_clr_i = 1'b1;
    @(posedge clk); #1;
    ovf_clr_i = 1'b0;
    m_ovf = 1'b0;
    check("ovf_cleared", 96'(overflow_o), 96'(m_ovf));
    drain();

    // Multi-hot select at digit 2
    ready_mode = 0;
    idle(2);
    err_base = seen_err; merr_base = m_err;
    drive(12'h001, pat_of("C"));
    drive(12'h002, pat_of("A"));
    drive(12'h003, pat_of("P"));
    for (int k = 3; k < ND; k++) drive(12'(1) << k, pat_of("E"));
    idle(4);
    check("badsel_err_cycles", 96'(seen_err - err_base), 96'(1));
    check("badsel_model_err", 96'(seen_err - err_base), 96'(m_err - merr_base));
    check("badsel_no_commit", 96'(frame_valid_o), 96'(0));
    send_str("SALIDA TOPE ", 1);
    idle(4);
    drain();

    // Stream starting mid-scan at digit 5
    idle(2);
    err_base = seen_err;
    for (int k = 5; k < ND; k++) drive(12'(1) << k, pat_of("O"));
    drive(12'h001, pat_of("D"));
    cnt = 0;
    for (int k = 1; k < ND; k++) begin
      drive(12'(1) << k, pat_of("L"));
      cnt++;
    end
    while (!frame_valid_o && cnt < 30) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("start_mid_latency", 96'(cnt), 96'(13));
    idle(4);
    drain();
    check("start_mid_no_err", 96'(seen_err - err_base), 96'(0));

    // Unknown pattern on digit 4
    ready_mode = 2;
    idle(2);
    for (int k = 0; k < ND; k++)
      drive(12'(1) << k, (k == 4) ? 14'h3FFF : pat_of("T"));
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("unk_mask", 96'(unknown_o), 96'(12'h010));
    check("unk_char4", 96'(frame_chars_o[39:32]), 96'(8'h3F));
    idle(3);
    drain();

    // Asynchronous reset mid-collection with a frame held
    ready_mode = 1;
    idle(2);
    send_str("SUELO TAPIA ", 1);
    idle(3);
    for (int k = 0; k < 8; k++) drive(12'(1) << k, pat_of("A"));
    #2;
    rst_n  = 1'b0;
    sel_i  = '0;
    segm_i = '0;
    #1;
    check("async_rst_valid", 96'(frame_valid_o), 96'(0));
    check("async_rst_chars", frame_chars_o, 96'(0));
    check("async_rst_unknown", 96'(unknown_o), 96'(0));
    check("async_rst_ovf", 96'(overflow_o), 96'(0));
    sb_q.delete();
    m_collect = 1'b0; m_ovf = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    ready_mode = 0;
    idle(1);
    send_str("LA CIUDAD  ", 1);
    idle(4);
    drain();

    // Each digit held for three clocks
    idle(2);
    err_base = seen_err; merr_base = m_err;
    send_str("PISTA OCULTA", 3);
    idle(4);
    drain();
    check("hold_model_err", 96'(seen_err - err_base), 96'(m_err - merr_base));
`ifdef SEG14_SCAN_HOLD_EN
    check("hold_no_err", 96'(seen_err - err_base), 96'(0));
`else
    check("nohold_err_seen", 96'(seen_err - err_base != 0), 96'(1));
`endif

    // Randomized scans with junk gaps, corrupt selects and odd patterns
    ready_mode = 0;
    idle(2);
    err_base = seen_err; merr_base = m_err;
    for (int it = 0; it < 30; it++) begin
      nj = $urandom_range(0, 4);
      for (int j = 0; j < nj; j++) begin
        case ($urandom_range(0, 2))
          0:       js = '0;
          1:       js = 12'(1) << $urandom_range(1, 11);
          default: js = 12'($urandom);
        endcase
        drive(js, 14'($urandom));
      end
      bad_pos = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 11) : -1;
      for (int k = 0; k < ND; k++) begin
        chs[k]  = font_chr[$urandom_range(0, 11)];
        pats[k] = ($urandom_range(0, 9) == 0) ? 14'($urandom) : pat_of(chs[k]);
        drive((k == bad_pos) ? 12'($urandom) : (12'(1) << k), pats[k]);
      end
      idle($urandom_range(1, 3));
    end
    idle(4);
    drain();
    check("rand_err_count", 96'(seen_err - err_base), 96'(m_err - merr_base));
    check("rand_no_ovf", 96'(overflow_o), 96'(m_ovf));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
